// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one fixed-latency single-ported memory between instruction fetch
// and the data (load/store) stage. Data has priority; fetch is guaranteed a grant
// after STARVE_MAX consecutive data grants made while it was waiting.
module mem_port_arbiter #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned MEM_LAT    = 2,
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned      CNT_W      = 4;
   localparam logic [CNT_W-1:0] LAT_LOAD   = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wait_q, wait_d;
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              win_fetch_q, win_fetch_d;
   logic              grant_fetch;

   logic              if_ack_d, d_ack_d, mem_en_d, mem_we_d, busy_d;
   logic [DATA_W-1:0] if_rdata_d, d_rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0] mem_addr_d;
   logic [3:0]        mem_be_d;

   // State and registered outputs; synchronous active-low reset abandons any access.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         wait_q      <= '0;
         starve_q    <= '0;
         win_fetch_q <= 1'b0;
         if_ack      <= 1'b0;
         if_rdata    <= '0;
         d_ack       <= 1'b0;
         d_rdata     <= '0;
         mem_en      <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
         mem_be      <= '0;
         busy        <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         starve_q    <= starve_d;
         win_fetch_q <= win_fetch_d;
         if_ack      <= if_ack_d;
         if_rdata    <= if_rdata_d;
         d_ack       <= d_ack_d;
         d_rdata     <= d_rdata_d;
         mem_en      <= mem_en_d;
         mem_we      <= mem_we_d;
         mem_addr    <= mem_addr_d;
         mem_wdata   <= mem_wdata_d;
         mem_be      <= mem_be_d;
         busy        <= busy_d;
      end
   end

   // Next-state, arbitration and next values of the output registers.
   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      starve_d    = starve_q;
      win_fetch_d = win_fetch_q;
      if_ack_d    = 1'b0;
      d_ack_d     = 1'b0;
      if_rdata_d  = if_rdata;
      d_rdata_d   = d_rdata;
      mem_en_d    = mem_en;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      mem_be_d    = mem_be;
      busy_d      = busy;
      grant_fetch = if_req && (!d_req || (starve_q == STARVE_LIM));

      unique case (state_q)
         IDLE: begin
            if (if_req || d_req) begin
               win_fetch_d = grant_fetch;
               mem_en_d    = 1'b1;
               busy_d      = 1'b1;
               wait_d      = LAT_LOAD;
               state_d     = ACCESS;
               if (grant_fetch) begin
                  mem_we_d    = 1'b0;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = '0;
                  mem_be_d    = 4'hF;
                  starve_d    = '0;
               end else begin
                  mem_we_d    = d_we;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
                  mem_be_d    = d_be;
                  if (!if_req)
                     starve_d = '0;
                  else if (starve_q != STARVE_LIM)
                     starve_d = starve_q + CNT_W'(1);
               end
            end
         end
         ACCESS: begin
            if (wait_q == '0) begin
               if (win_fetch_q) begin
                  if_ack_d   = 1'b1;
                  if_rdata_d = mem_rdata;
               end else begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = mem_we ? '0 : mem_rdata;
               end
               mem_en_d    = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = '0;
               mem_wdata_d = '0;
               mem_be_d    = '0;
               state_d     = DONE;
            end else begin
               wait_d = wait_q - CNT_W'(1);
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: cycle-by-cycle vector table plus
// hand-written sequences for contention, starvation bound and mid-access reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [3:0]  d_be;
   logic        if_ack, d_ack, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [3:0]  mem_be;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
   );

   typedef struct {
      logic        rst;
      logic        if_req;
      logic [31:0] if_addr;
      logic        d_req;
      logic        d_we;
      logic [31:0] d_addr;
      logic [31:0] d_wdata;
      logic [3:0]  d_be;
      logic [31:0] mem_rdata;
      logic        e_if_ack;
      logic        e_d_ack;
      logic        e_mem_en;
      logic        e_mem_we;
      logic [31:0] e_mem_addr;
      logic [31:0] e_mem_wdata;
      logic [3:0]  e_mem_be;
      logic [31:0] e_if_rdata;
      logic [31:0] e_d_rdata;
      logic        e_busy;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs [NV];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      rst       = v.rst;
      if_req    = v.if_req;
      if_addr   = v.if_addr;
      d_req     = v.d_req;
      d_we      = v.d_we;
      d_addr    = v.d_addr;
      d_wdata   = v.d_wdata;
      d_be      = v.d_be;
      mem_rdata = v.mem_rdata;
   endtask

   initial begin
      int ifa_c, da_c, n, acks;
      int got [15];

      // Each row: inputs sampled at the next edge, expected outputs after it.
      vecs[0]  = '{1'b0, 1'b1, 32'hAAAA5555, 1'b1, 1'b1, 32'h1234, 32'hFFFF, 4'hF, 32'h777,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h9, 4'h5, 32'h1,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0};
      vecs[3]  = vecs[2];
      vecs[4]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0, 32'h0, 1'b1};
      vecs[5]  = vecs[4];
      vecs[6]  = '{1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13,
                   1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 32'h0, 1'b1};
      vecs[7]  = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 32'h0, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 32'hDEADBEEF, 4'h3, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b1, 32'h204, 32'hDEADBEEF, 4'h3, 32'h13, 32'h0, 1'b1};
      vecs[9]  = vecs[8];
      vecs[10] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 32'hDEADBEEF, 4'h3, 32'h55,
                   1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 32'h0, 1'b1};
      vecs[11] = vecs[7];
      vecs[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h0,
                   1'b0, 1'b0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'h13, 32'h0, 1'b1};
      vecs[13] = vecs[12];
      vecs[14] = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 32'hCAFEF00D,
                   1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 32'hCAFEF00D, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                   1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h13, 32'hCAFEF00D, 1'b0};

      for (int i = 0; i < NV; i++) begin
         apply(vecs[i]);
         step();
         chk($sformatf("v%0d if_ack", i),    32'(if_ack),    32'(vecs[i].e_if_ack));
         chk($sformatf("v%0d d_ack", i),     32'(d_ack),     32'(vecs[i].e_d_ack));
         chk($sformatf("v%0d mem_en", i),    32'(mem_en),    32'(vecs[i].e_mem_en));
         chk($sformatf("v%0d mem_we", i),    32'(mem_we),    32'(vecs[i].e_mem_we));
         chk($sformatf("v%0d mem_addr", i),  mem_addr,       vecs[i].e_mem_addr);
         chk($sformatf("v%0d mem_wdata", i), mem_wdata,      vecs[i].e_mem_wdata);
         chk($sformatf("v%0d mem_be", i),    32'(mem_be),    32'(vecs[i].e_mem_be));
         chk($sformatf("v%0d if_rdata", i),  if_rdata,       vecs[i].e_if_rdata);
         chk($sformatf("v%0d d_rdata", i),   d_rdata,        vecs[i].e_d_rdata);
         chk($sformatf("v%0d busy", i),      32'(busy),      32'(vecs[i].e_busy));
      end

      // Simultaneous requests: data first (ack cycle 3), fetch next (ack cycle 7).
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; d_wdata = 32'h0; d_be = 4'hF;
      mem_rdata = 32'h0BADF00D;
      ifa_c = -1; da_c = -1;
      for (int c = 1; c <= 20 && (ifa_c < 0 || da_c < 0); c++) begin
         step();
         if (d_ack) begin da_c = c; d_req = 1'b0; end
         if (if_ack) begin ifa_c = c; if_req = 1'b0; end
      end
      chk("contend d_ack cycle",  32'(da_c),  32'd3);
      chk("contend if_ack cycle", 32'(ifa_c), 32'd7);
      chk("contend if_rdata",     if_rdata,   32'h0BADF00D);
      chk("contend d_rdata",      d_rdata,    32'h0BADF00D);

      // Both held: four data grants, then one forced fetch grant, repeating.
      if_req = 1'b1; d_req = 1'b1;
      n = 0;
      for (int c = 0; c < 200 && n < 15; c++) begin
         step();
         if (d_ack)  begin got[n] = 0; n++; end
         if (if_ack) begin got[n] = 1; n++; end
      end
      if_req = 1'b0; d_req = 1'b0;
      chk("starve ack count", 32'(n), 32'd15);
      for (int k = 0; k < 15; k++)
         chk($sformatf("starve grant %0d is_fetch", k), 32'(got[k]), ((k % 5) == 4) ? 32'd1 : 32'd0);
      for (int c = 0; c < 10 && busy; c++) step();
      chk("starve idle busy", 32'(busy), 32'd0);

      // Reset during the second ACCESS cycle abandons the access.
      if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'h13579BDF;
      step();
      chk("rstmid access1 mem_en", 32'(mem_en), 32'd1);
      step();
      chk("rstmid access2 mem_en", 32'(mem_en), 32'd1);
      rst = 1'b0;
      step();
      chk("rstmid mem_en",   32'(mem_en), 32'd0);
      chk("rstmid busy",     32'(busy),   32'd0);
      chk("rstmid if_rdata", if_rdata,    32'h0);
      chk("rstmid mem_addr", mem_addr,    32'h0);
      rst = 1'b1; if_req = 1'b0;
      acks = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         if (if_ack || d_ack) acks++;
      end
      chk("rstmid no ack", 32'(acks), 32'd0);

      // Fresh request after the aborted one is served normally.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600; mem_rdata = 32'h2468ACE0;
      da_c = -1;
      for (int c = 1; c <= 10 && da_c < 0; c++) begin
         step();
         if (c == 1) chk("reissue mem_addr", mem_addr, 32'h600);
         if (d_ack) begin da_c = c; d_req = 1'b0; end
      end
      chk("reissue d_ack cycle", 32'(da_c), 32'd3);
      chk("reissue d_rdata",     d_rdata,   32'h2468ACE0);
      chk("reissue if_ack",      32'(if_ack), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
